// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU core.
// The ALU_SEQ_DIV_EN macro selects DIV or AND for op code 11.
package alu_pkg;

    localparam int ALU_N = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_X11 = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply (shift-add) and optional restoring divide (ALU_SEQ_DIV_EN).
// result is the value the working register takes after the current step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   result
);

    // pr_r is {high, low}: {accumulator, multiplier} or {remainder, quotient}
    logic [2*N-1:0] pr_r;
    logic [N-1:0]   opb_r;
    logic [N:0]     sum_s;
    logic [2*N-1:0] next_s;
`ifdef ALU_SEQ_DIV_EN
    logic [N:0]     sh_s;
    logic [N:0]     diff_s;
`endif

    // One step of the selected algorithm
    always_comb begin
        sum_s  = {1'b0, pr_r[2*N-1:N]} + (pr_r[0] ? {1'b0, opb_r} : {(N+1){1'b0}});
        next_s = {sum_s, pr_r[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
        sh_s   = {pr_r[2*N-1:N], pr_r[N-1]};
        diff_s = sh_s - {1'b0, opb_r};
        if (is_div) begin
            // A zero divisor always "fits", giving all-ones quotient and remainder = A
            if (sh_s >= {1'b0, opb_r}) begin
                next_s = {diff_s[N-1:0], pr_r[N-2:0], 1'b1};
            end else begin
                next_s = {sh_s[N-1:0], pr_r[N-2:0], 1'b0};
            end
        end else begin
            next_s = {sum_s, pr_r[N-1:1]};
        end
`endif
    end

    assign result = next_s;

    // Working registers: load on start, advance on step
    always_ff @(posedge clk) begin
        if (reset) begin
            pr_r  <= {(2*N){1'b0}};
            opb_r <= {N{1'b0}};
        end else if (start) begin
            pr_r  <= {{N{1'b0}}, a};
            opb_r <= b;
        end else if (step) begin
            pr_r  <= next_s;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU responder: valid/ready input, one-cycle out_valid strobe.
// ALU_SEQ_DIV_EN defined: op 11 is iterative DIV; undefined: op 11 is 1-cycle AND.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     inp1,
    input  logic [N-1:0]     inp2,
    input  logic [1:0]       op_code,
    output logic             out_valid,
    output logic [2*N-1:0]   outp
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    alu_state_e     state_r, state_next_s;
    logic [CW-1:0]  count_r, count_next_s;
    logic [2*N-1:0] outp_r, outp_next_s;
    logic           out_valid_r, out_valid_next_s;
    logic           in_ready_r;
    logic           accept_s, start_s, step_s;
    logic [2*N-1:0] a_ext_s, b_ext_s, iter_result_s;
`ifdef ALU_SEQ_DIV_EN
    logic           div_r, div_next_s;
`endif

    alu_iter_unit #(.N(N)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .step   (step_s),
`ifdef ALU_SEQ_DIV_EN
        .is_div (div_r),
`endif
        .a      (inp1),
        .b      (inp2),
        .result (iter_result_s)
    );

    // Next-state, 1-cycle results and iteration control
    always_comb begin
        a_ext_s          = {{N{1'b0}}, inp1};
        b_ext_s          = {{N{1'b0}}, inp2};
        accept_s         = in_valid && in_ready_r;
        state_next_s     = state_r;
        count_next_s     = count_r;
        outp_next_s      = outp_r;
        out_valid_next_s = 1'b0;
        start_s          = 1'b0;
        step_s           = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        div_next_s       = div_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                state_next_s = IDLE;
                if (accept_s) begin
                    case (alu_op_e'(op_code))
                        OP_ADD: begin
                            outp_next_s      = a_ext_s + b_ext_s;
                            out_valid_next_s = 1'b1;
                        end
                        OP_SUB: begin
                            outp_next_s      = a_ext_s - b_ext_s;
                            out_valid_next_s = 1'b1;
                        end
                        OP_MUL: begin
                            start_s      = 1'b1;
                            state_next_s = ITER;
                            count_next_s = CNT_LOAD;
`ifdef ALU_SEQ_DIV_EN
                            div_next_s   = 1'b0;
`endif
                        end
                        OP_X11: begin
`ifdef ALU_SEQ_DIV_EN
                            start_s      = 1'b1;
                            state_next_s = ITER;
                            count_next_s = CNT_LOAD;
                            div_next_s   = 1'b1;
`else
                            outp_next_s      = a_ext_s & b_ext_s;
                            out_valid_next_s = 1'b1;
`endif
                        end
                        default: begin
                            state_next_s = IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            ITER: begin
                step_s = 1'b1;
                // The final step's result goes straight into outp
                if (count_r == {CW{1'b0}}) begin
                    state_next_s     = DONE;
                    outp_next_s      = iter_result_s;
                    out_valid_next_s = 1'b1;
                end else begin
                    count_next_s = count_r - CW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            outp_r      <= {(2*N){1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            div_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            outp_r      <= outp_next_s;
            out_valid_r <= out_valid_next_s;
            in_ready_r  <= (state_next_s != ITER);
`ifdef ALU_SEQ_DIV_EN
            div_r       <= div_next_s;
`endif
        end
    end

    assign outp      = outp_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (N=8): directed cases plus random ops
// checked against an arithmetic reference model; follows ALU_SEQ_DIV_EN.
module tb_alu_seq_core;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   inp1;
    logic [N-1:0]   inp2;
    logic [1:0]     op_code;
    logic           out_valid;
    logic [2*N-1:0] outp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .op_code   (op_code),
        .out_valid (out_valid),
        .outp      (outp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        ua = a;
        ub = b;
        case (op)
            2'd0:    r = (ua + ub) % 65536;
            2'd1:    r = (ua + 65536 - ub) % 65536;
            2'd2:    r = ua * ub;
`ifdef ALU_SEQ_DIV_EN
            default: r = (ub == 0) ? (ua * 256 + 255) : ((ua % ub) * 256 + ua / ub);
`else
            default: r = ua & ub;
`endif
        endcase
        return r[15:0];
    endfunction

    function automatic int ref_latency(input logic [1:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op >= 2'd2) ? N + 1 : 1;
`else
        return (op == 2'd2) ? N + 1 : 1;
`endif
    endfunction

    // One operation: drive, scramble inputs after accept, poke in_valid while busy, check.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
        int lat;
        int exp_lat;
        bit got;
        exp_lat = ref_latency(op);
        @(negedge clk);
        check({tag, "_ready_pre"}, in_ready, 1);
        in_valid = 1'b1;
        op_code  = op;
        inp1     = a;
        inp2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_code  = 2'($urandom);
        inp1     = 8'($urandom);
        inp2     = 8'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < exp_lat + 3) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                check({tag, "_busy"}, in_ready, 0);
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, got ? lat : -1, exp_lat);
        check({tag, "_outp"}, outp, exp);
        check({tag, "_ready_done"}, in_ready, 1);
        @(negedge clk);
        check({tag, "_strobe_end"}, out_valid, 0);
        check({tag, "_hold"}, outp, exp);
    endtask

    initial begin
        bit seen;
        logic [1:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;

        reset    = 1'b1;
        in_valid = 1'b0;
        inp1     = 8'h00;
        inp2     = 8'h00;
        op_code  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outp", outp, 0);
        check("reset_valid", out_valid, 0);
        check("reset_ready", in_ready, 1);
        reset = 1'b0;

        run_op(2'd0, 8'hFF, 8'h01, 16'h0100, "add_carry");
        run_op(2'd1, 8'h03, 8'h05, 16'hFFFE, "sub_borrow");
        run_op(2'd2, 8'hFF, 8'hFF, 16'hFE01, "mul_max");
`ifdef ALU_SEQ_DIV_EN
        run_op(2'd3, 8'd200, 8'd7, 16'h041C, "div_200_7");
        run_op(2'd3, 8'h2A, 8'h00, 16'h2AFF, "div_by_zero");
`else
        run_op(2'd3, 8'hF0, 8'h3C, 16'h0030, "and_op");
`endif

        // Three back-to-back ADDs: one strobe per cycle
        @(negedge clk);
        in_valid = 1'b1; op_code = 2'd0; inp1 = 8'h10; inp2 = 8'h20;
        @(negedge clk);
        check("b2b_valid0", out_valid, 1);
        check("b2b_outp0", outp, 16'h0030);
        inp1 = 8'h80; inp2 = 8'h80;
        @(negedge clk);
        check("b2b_valid1", out_valid, 1);
        check("b2b_outp1", outp, 16'h0100);
        op_code = 2'd1; inp1 = 8'h00; inp2 = 8'h01;
        @(negedge clk);
        check("b2b_valid2", out_valid, 1);
        check("b2b_outp2", outp, 16'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_end", out_valid, 0);

        // Reset during cycle 4 of a MUL aborts it
        in_valid = 1'b1; op_code = 2'd2; inp1 = 8'hFF; inp2 = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_outp", outp, 0);
        check("abort_ready", in_ready, 1);
        reset = 1'b0;
        seen = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);
        run_op(2'd0, 8'h01, 8'h01, 16'h0002, "add_after_abort");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom);
            rb  = (i % 10 == 3) ? 8'h00 : 8'($urandom);
            run_op(rop, ra, rb, ref_result(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
